// File: rtl/gray_tap_selector.sv
// Selects tap_in[b-TAP_LSB] when the gray timebase changes in exactly one in-window bit b.
// Latency: 1 edge from gray/tap sample to registered out_muxed, sel_idx, sel_valid and toggle_strobe.
// Backpressure: none; en=0 freezes state and forces a re-prime before detection resumes.
module gray_tap_selector #(
  parameter int N_TAPS  = 10,
  parameter int GRAY_W  = 17,
  parameter int TAP_LSB = 1,
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              en,
  input  logic [GRAY_W-1:0] gray_in,
  input  logic [N_TAPS-1:0] tap_in,
  input  logic              hold_mode,
  output logic              out_muxed,
  output logic [IDX_W-1:0]  sel_idx,
  output logic              sel_valid,
  output logic              toggle_strobe,
  output logic              gray_err
);

  generate
    if (N_TAPS < 1 || TAP_LSB < 0 || TAP_LSB + N_TAPS > GRAY_W) begin : g_bad_cfg
      $error("gray_tap_selector: tap window does not fit inside the gray timebase");
    end
  endgenerate

  logic [GRAY_W-1:0] gray_q;
  logic              primed;

  logic [GRAY_W-1:0] diff;
  logic              multi;
  logic              in_win;
  logic [IDX_W-1:0]  hit_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_valid;
  logic              nxt_bit;

  always_comb begin
    diff    = gray_in ^ gray_q;
    // Clearing the lowest set bit leaves something only when two or more bits flipped.
    multi   = |(diff & (diff - GRAY_W'(1)));
    hit_idx = '0;
    in_win  = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (diff[TAP_LSB + i]) begin
        hit_idx = IDX_W'(i);
        in_win  = ~multi;
      end
    end

    nxt_idx   = sel_idx;
    nxt_valid = sel_valid;
    if (primed) begin
      if (in_win) begin
        nxt_idx   = hit_idx;
        nxt_valid = 1'b1;
      end else if (!hold_mode) begin
        nxt_valid = 1'b0;
      end
    end

    nxt_bit = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (nxt_idx == IDX_W'(i)) nxt_bit = tap_in[i];
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      gray_q        <= '0;
      primed        <= 1'b0;
      out_muxed     <= 1'b0;
      sel_idx       <= '0;
      sel_valid     <= 1'b0;
      toggle_strobe <= 1'b0;
      gray_err      <= 1'b0;
    end else if (!en) begin
      primed        <= 1'b0;
      toggle_strobe <= 1'b0;
    end else begin
      gray_q        <= gray_in;
      primed        <= 1'b1;
      toggle_strobe <= primed & in_win;
      if (primed && multi) gray_err <= 1'b1;
      sel_idx       <= nxt_idx;
      sel_valid     <= nxt_valid;
      out_muxed     <= nxt_valid & nxt_bit;
    end
  end

endmodule

// File: tb/tb_gray_tap_selector.sv
// Randomized and directed bench for gray_tap_selector against a behavioural model.
module tb_gray_tap_selector;

  localparam int N_TAPS  = 10;
  localparam int GRAY_W  = 17;
  localparam int TAP_LSB = 1;
  localparam int IDX_W   = 4;

  logic              clk_ext = 1'b0;
  logic              rst;
  logic              en;
  logic [GRAY_W-1:0] gray_in;
  logic [N_TAPS-1:0] tap_in;
  logic              hold_mode;
  logic              out_muxed;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_valid;
  logic              toggle_strobe;
  logic              gray_err;

  gray_tap_selector #(.N_TAPS(N_TAPS), .GRAY_W(GRAY_W), .TAP_LSB(TAP_LSB)) dut (
    .clk_ext      (clk_ext),
    .rst          (rst),
    .en           (en),
    .gray_in      (gray_in),
    .tap_in       (tap_in),
    .hold_mode    (hold_mode),
    .out_muxed    (out_muxed),
    .sel_idx      (sel_idx),
    .sel_valid    (sel_valid),
    .toggle_strobe(toggle_strobe),
    .gray_err     (gray_err)
  );

  always #5 clk_ext = ~clk_ext;

  int total = 0;
  int bad   = 0;

  // Reference state: last sampled gray word, priming flag, and the visible outputs.
  logic [GRAY_W-1:0] m_gray = '0;
  bit m_primed = 0;
  int m_idx    = 0;
  bit m_valid  = 0;
  bit m_out    = 0;
  bit m_strobe = 0;
  bit m_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [GRAY_W-1:0] d;
    int n, b;
    bit evt;
    if (rst) begin
      m_gray = '0; m_primed = 0; m_idx = 0; m_valid = 0;
      m_out = 0; m_strobe = 0; m_err = 0;
    end else if (!en) begin
      m_primed = 0; m_strobe = 0;
    end else begin
      evt = 0;
      if (m_primed) begin
        d = gray_in ^ m_gray;
        n = $countones(d);
        if (n >= 2) m_err = 1;
        if (n == 1) begin
          b = 0;
          while (d[b] == 1'b0) b++;
          if (b >= TAP_LSB && b < TAP_LSB + N_TAPS) begin
            evt = 1; m_idx = b - TAP_LSB; m_valid = 1;
          end
        end
        if (!evt && !hold_mode) m_valid = 0;
      end
      m_strobe = evt;
      m_gray   = gray_in;
      m_primed = 1;
      m_out    = m_valid ? tap_in[m_idx] : 1'b0;
    end
  endtask

  // Applies one rising edge, then compares every output against the model.
  task automatic tick();
    model_edge();
    @(posedge clk_ext);
    #1;
    check_val("out_muxed", 32'(out_muxed), 32'(m_out));
    check_val("sel_idx", 32'(sel_idx), 32'(m_idx));
    check_val("sel_valid", 32'(sel_valid), 32'(m_valid));
    check_val("toggle_strobe", 32'(toggle_strobe), 32'(m_strobe));
    check_val("gray_err", 32'(gray_err), 32'(m_err));
  endtask

  initial begin
    logic [GRAY_W-1:0] flips;
    logic [GRAY_W-1:0] clean_seq [5];
    int r;
    clean_seq[0] = 17'h00002; clean_seq[1] = 17'h00004; clean_seq[2] = 17'h00040;
    clean_seq[3] = 17'h00200; clean_seq[4] = 17'h00400;

    rst = 1; en = 1; gray_in = 17'h1FFFF; tap_in = 10'h3FF; hold_mode = 1;
    repeat (3) tick();
    check_val("rst_out", 32'(out_muxed), 0);
    check_val("rst_idx", 32'(sel_idx), 0);
    check_val("rst_valid", 32'(sel_valid), 0);
    check_val("rst_strobe", 32'(toggle_strobe), 0);
    check_val("rst_err", 32'(gray_err), 0);

    rst = 0; gray_in = 17'h00000;
    tick();
    check_val("prime_strobe", 32'(toggle_strobe), 0);
    gray_in = 17'h00008; tap_in = 10'h004;
    tick();
    check_val("evt_strobe", 32'(toggle_strobe), 1);
    check_val("evt_idx", 32'(sel_idx), 2);
    check_val("evt_valid", 32'(sel_valid), 1);
    check_val("evt_out", 32'(out_muxed), 1);

    tap_in = 10'h000; tick();
    check_val("hold_out0", 32'(out_muxed), 0);
    check_val("hold_strobe_once", 32'(toggle_strobe), 0);
    tap_in = 10'h004; tick();
    check_val("hold_out1", 32'(out_muxed), 1);
    hold_mode = 0; tick();
    check_val("nohold_valid", 32'(sel_valid), 0);
    check_val("nohold_out", 32'(out_muxed), 0);

    hold_mode = 1;
    gray_in = 17'h00009; tick();
    check_val("bit0_strobe", 32'(toggle_strobe), 0);
    check_val("bit0_idx", 32'(sel_idx), 2);
    check_val("bit0_err", 32'(gray_err), 0);
    gray_in = 17'h01009; tick();
    check_val("bit12_strobe", 32'(toggle_strobe), 0);
    check_val("bit12_idx", 32'(sel_idx), 2);
    check_val("bit12_err", 32'(gray_err), 0);
    gray_in = 17'h00009; tick();
    gray_in = 17'h00008; tick();

    gray_in = 17'h00030; tick();
    check_val("multi_err", 32'(gray_err), 1);
    check_val("multi_idx", 32'(sel_idx), 2);
    check_val("multi_strobe", 32'(toggle_strobe), 0);
    for (int i = 0; i < 5; i++) begin
      gray_in = gray_in ^ clean_seq[i];
      tap_in = 10'($urandom);
      tick();
      check_val("sticky_err", 32'(gray_err), 1);
      check_val("sticky_strobe", 32'(toggle_strobe), 1);
    end
    rst = 1; tick();
    check_val("err_clear", 32'(gray_err), 0);
    rst = 0;

    tick();
    en = 0; gray_in = gray_in ^ 17'h000F0; tick();
    check_val("dis_strobe", 32'(toggle_strobe), 0);
    en = 1; tick();
    check_val("reprime_err", 32'(gray_err), 0);
    check_val("reprime_strobe", 32'(toggle_strobe), 0);
    gray_in = gray_in ^ 17'h00008; tick();
    check_val("after_strobe", 32'(toggle_strobe), 1);
    check_val("after_idx", 32'(sel_idx), 2);
    check_val("after_err", 32'(gray_err), 0);

    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      en        = ($urandom_range(0, 9) != 0);
      hold_mode = $urandom_range(0, 1);
      tap_in    = 10'($urandom);
      r = $urandom_range(0, 19);
      flips = '0;
      if (r < 12) flips[$urandom_range(0, GRAY_W - 1)] = 1'b1;
      else if (r < 14) begin
        flips[$urandom_range(0, 7)] = 1'b1;
        flips[$urandom_range(8, GRAY_W - 1)] = 1'b1;
      end else if (r == 14) flips = 17'($urandom);
      gray_in = gray_in ^ flips;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_tap_selector.md
GRAY_TAP_SELECTOR -- requirements
Module: gray_tap_selector

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 10: number of selectable taps.
REQ-002 The block SHALL have parameter GRAY_W, default 17: width of the gray-code timebase input.
REQ-003 The block SHALL have parameter TAP_LSB, default 1: gray bit mapped to tap index 0.
REQ-004 The block SHALL have port clk_ext, input, 1 bit: the single core clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: global enable.
REQ-007 The block SHALL have port gray_in, input, GRAY_W bits: gray-code timebase.
REQ-008 The block SHALL have port tap_in, input, N_TAPS bits: candidate data bits.
REQ-009 The block SHALL have port hold_mode, input, 1 bit: 1 holds the last selection, 0 selects for one cycle per event.
REQ-010 The block SHALL have port out_muxed, output, 1 bit: registered selected tap value.
REQ-011 The block SHALL have port sel_idx, output, clog2(N_TAPS) bits (minimum 1): current tap index.
REQ-012 The block SHALL have port sel_valid, output, 1 bit: sel_idx is meaningful.
REQ-013 The block SHALL have port toggle_strobe, output, 1 bit: one-cycle pulse on an in-window selection event.
REQ-014 The block SHALL have port gray_err, output, 1 bit: sticky flag for a multi-bit gray change.

Function
REQ-015 The design SHALL reject, at elaboration, any configuration violating N_TAPS>=1 or TAP_LSB+N_TAPS<=GRAY_W.
REQ-016 Internal state SHALL be: gray_q (GRAY_W bits), primed (1 bit), and all output registers.
REQ-017 On an edge with en=1 and primed=0, the block SHALL load gray_q<=gray_in and set primed<=1, with no event detection, toggle_strobe=0, and selection unchanged.
REQ-018 On an edge with en=1 and primed=1, the block SHALL compute diff=gray_in^gray_q, then load gray_q<=gray_in.
REQ-019 When popcount(diff)==0, no event SHALL occur.
REQ-020 When popcount(diff)==1 at bit b with TAP_LSB<=b<TAP_LSB+N_TAPS, the block SHALL set sel_idx<=b-TAP_LSB, sel_valid<=1 and toggle_strobe<=1 on that edge.
REQ-021 When popcount(diff)==1 at a bit outside the window, selection SHALL be unchanged and toggle_strobe<=0.
REQ-022 When popcount(diff)>=2, the block SHALL set gray_err<=1, leave selection unchanged and set toggle_strobe<=0; gray_err SHALL stay 1 until rst.
REQ-023 When hold_mode=0, sel_valid SHALL clear to 0 on any enabled, primed edge without an in-window event.
REQ-024 When hold_mode=1, sel_valid and sel_idx SHALL persist across non-event edges.
REQ-025 On every enabled edge, out_muxed SHALL be loaded with tap_in[next sel_idx] if next sel_valid=1, else 0. Latency is 1 edge: the same edge that registers an event updates out_muxed from tap_in sampled at that edge.
REQ-026 toggle_strobe SHALL be high for exactly one cycle per event, and SHALL be 0 on any edge with en=0.
REQ-027 On an edge with en=0, the block SHALL clear primed<=0 and toggle_strobe<=0, and all other registers SHALL hold; gray changes while disabled SHALL NOT set gray_err.
REQ-028 tap_in changes without a gray event SHALL propagate to out_muxed on the next enabled edge while sel_valid=1.

Reset
REQ-029 With rst=1 at an edge, the block SHALL force out_muxed=0, sel_idx=0, sel_valid=0, toggle_strobe=0, gray_err=0, primed=0, gray_q=0, regardless of en.
REQ-030 rst SHALL take priority over en and over any simultaneous gray event.
REQ-031 rst asserted mid-operation SHALL abandon the current selection; the first enabled edge after release SHALL be a priming edge (REQ-017).

Verification (N_TAPS=10, GRAY_W=17, TAP_LSB=1)
REQ-032 The bench SHALL drive rst=1 for 3 edges with en=1, gray_in=0x1FFFF and tap_in=0x3FF, and check that all outputs are 0.
REQ-033 The bench SHALL release rst with en=1 and gray_in=0x00000 (priming edge, no strobe), then drive gray_in=0x00008 with tap_in=0x004, and check on that edge: toggle_strobe=1, sel_idx=2, sel_valid=1, out_muxed=1.
REQ-034 With hold_mode=1 and gray_in held, the bench SHALL drive tap_in=0x000, check out_muxed=0 next edge, then tap_in=0x004 and check out_muxed=1; it SHALL then set hold_mode=0 and check sel_valid=0 and out_muxed=0 after one non-event edge.
REQ-035 The bench SHALL drive gray_in 0x00008->0x00009 (bit 0) and then ->0x01009 (bit 12), and check toggle_strobe=0, sel_idx unchanged and gray_err=0.
REQ-036 The bench SHALL drive gray_in 0x00008->0x00030 and check gray_err=1 and selection unchanged; it SHALL check gray_err stays 1 over 5 further clean events and clears only on rst.
REQ-037 The bench SHALL drop en, change gray_in by 4 bits, then re-assert en, and check: no gray_err, no strobe on the priming edge, and normal detection on the next single-bit change.
